// File: rtl/rr_enq_arbiter.sv
// rr_enq_arbiter: round-robin N:1 arbiter feeding a registered valid/ready output stage.
// Define RR_ENQ_ARBITER_ARB_LOCK_EN to add in_last and hold the grant until end of packet.
module rr_enq_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int NUM_PORTS = 4,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] in_data,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [DATA_SIZE-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IW-1:0]                  out_id,
  input  logic                           flush
`ifdef RR_ENQ_ARBITER_ARB_LOCK_EN
  ,
  input  logic [NUM_PORTS-1:0]           in_last
`endif
);
  logic                 out_valid_q, out_valid_d, lock_q, lock_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d, beat;
  logic [IW-1:0]        out_id_q, out_id_d, ptr_q, ptr_d, lock_id_q, lock_id_d, win, nxt;
  logic [NUM_PORTS-1:0] cand;
  logic [IW:0]          idx;
  logic                 any, gnt, hold_lock;
  // Cyclic search from ptr; a held lock narrows the candidates to the locked port.
  always_comb begin
    cand = lock_q ? in_valid & (NUM_PORTS'(1) << lock_id_q) : in_valid;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(j);
      idx = idx >= (IW+1)'(NUM_PORTS) ? idx - (IW+1)'(NUM_PORTS) : idx;
      if (!any && cand[idx[IW-1:0]]) begin
        any = 1'b1;
        win = idx[IW-1:0];
      end
    end
  end
  always_comb begin
    beat = '0;
    for (int j = 0; j < NUM_PORTS; j++)
      if (win == IW'(j)) beat = in_data[j*DATA_SIZE +: DATA_SIZE];
  end
`ifdef RR_ENQ_ARBITER_ARB_LOCK_EN
  assign hold_lock = !in_last[win];
`else
  assign hold_lock = 1'b0;
`endif
  assign gnt      = any && (!out_valid_q || out_ready) && !flush && rst_n;
  assign in_ready = gnt ? NUM_PORTS'(1) << win : '0;
  assign nxt      = (win == IW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
  always_comb begin
    out_valid_d = !flush && (gnt || (out_valid_q && !out_ready));
    out_data_d  = gnt ? beat : out_data_q;
    out_id_d    = gnt ? win : out_id_q;
    ptr_d       = flush ? '0 : (gnt && !hold_lock) ? nxt : ptr_q;
    lock_d      = !flush && (gnt ? hold_lock : lock_q);
    lock_id_d   = gnt ? win : lock_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
endmodule
